alu_sel_ctrl: RTL and testbench
===============================

# alu_sel_ctrl

Registered, handshaked operand-select decoder for the control unit. Takes the one-hot instruction-class code and the raw instruction word and produces `alu_sel_a`, `alu_sel_b`, the ecall/ebreak flags and an illegal-code flag one cycle later on a valid/ready output. Class-to-select maps and the CSR class position are parameters. A trap sequencer stalls the input for a fixed number of cycles after any ecall, ebreak or illegal code is handed downstream.

## Interface
- `CODE_W`, 10, width of the one-hot class code.
- `SEL_A_MASK`, 10'b0000001001, bit i set means class i selects PC for operand A (J, AUIPC).
- `SEL_B_MASK`, 10'b0111001111, bit i set means class i selects the immediate for operand B.
- `CSR_IDX`, 9, bit position of the CSR/SYSTEM class in `code`.
- `TRAP_CYCLES`, 2, stall length after a trapping instruction; must be ≥1.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `in_valid`  in  1  upstream offers `code`/`insn`.
- `in_ready`  out  1  block accepts this cycle.
- `code`  in  CODE_W  one-hot instruction class.
- `insn`  in  32  raw instruction word.
- `out_valid`  out  1  registered result valid.
- `out_ready`  in  1  downstream consumes the result.
- `alu_sel_a`  out  1  1 = PC, 0 = rs1.
- `alu_sel_b`  out  1  1 = immediate, 0 = rs2.
- `is_ecall`, `is_ebreak`, `illegal`  out  1 each  decode flags.
- `trap_busy`  out  1  trap sequencer stalling.

## Operation
- Accept when `in_valid && in_ready`. `in_ready = rst_n && state==IDLE && (!out_valid || out_ready)`.
- One-hot check: if `code` does not have exactly one bit set:
  - `illegal=1`.
  - `alu_sel_a`, `alu_sel_b`, `is_ecall`, `is_ebreak` = 0.
- Otherwise:
  - `alu_sel_a = |(code & SEL_A_MASK) | (code[CSR_IDX] & insn[20])`.
  - `alu_sel_b = |(code & SEL_B_MASK)`.
- SYSTEM decode applies only when `code[CSR_IDX]`, `insn[31:21]==0`, `insn[19:7]==0` and `insn[6:0]==7'h73`:
  - `insn[20]==0` gives `is_ecall`.
  - `insn[20]==1` gives `is_ebreak`.
  - Otherwise the instruction is a Zicsr op and both flags are 0.
- A trapping result is one with `is_ecall`, `is_ebreak` or `illegal` set.
- FSM states:
  - IDLE: normal. On accept of a trapping instruction, go to WAIT_OUT.
  - WAIT_OUT: `in_ready=0`. On handoff (`out_valid && out_ready`), go to TRAP and load `cnt = TRAP_CYCLES-1`.
  - TRAP: `in_ready=0`, `trap_busy=1`. Decrement `cnt`; when `cnt==0`, go to IDLE next cycle.
- Arithmetic: `cnt` width is `$clog2(TRAP_CYCLES)+1`. It never wraps; it is loaded only on entry to TRAP.

## Timing
- Reset (`rst_n=0` at an edge):
  - `out_valid`, `alu_sel_a`, `alu_sel_b`, `is_ecall`, `is_ebreak`, `illegal`, `trap_busy` = 0.
  - state = IDLE, `cnt` = 0.
  - `in_ready=0` while `rst_n=0`.
- Reset mid-operation (WAIT_OUT or TRAP) discards the pending result and the stall.
- Latency: result registered on the accept edge; `out_valid` is high the following cycle.
- Backpressure: while `out_valid && !out_ready`, all outputs hold stable and `in_ready=0`.
- Simultaneous handoff and accept in IDLE: the new result replaces the old one in the same edge, giving 1 instruction/cycle throughput.
- Trap stall: exactly TRAP_CYCLES cycles of `trap_busy=1` start the cycle after the trapping result's handoff. `in_ready` rises the cycle after the last busy cycle.
- An `in_valid` arriving during a stall is held by upstream; nothing is dropped.

## Test plan
- Reset: hold `rst_n=0` 3 cycles with `in_valid=1` -> all outputs 0 and `in_ready=0`. First cycle after release -> `in_ready=1`.
- Class sweep (`out_ready=1`):
  - Drive each one-hot `code` 10'b1<<i with `insn=0`.
  - Required `{alu_sel_a, alu_sel_b}`: i=0 {1,1}; i=1 {0,1}; i=2 {0,1}; i=3 {1,1}; i=4 {0,0}; i=5 {0,0}; i=6 {0,1}; i=7 {0,1}; i=8 {0,1}.
  - Each result appears 1 cycle after accept, back-to-back.
- SYSTEM:
  - `code=10'h200`, `insn=32'h00000073` -> `is_ecall=1`, `alu_sel_a=0`, then `trap_busy` high exactly 2 cycles.
  - `insn=32'h00100073` -> `is_ebreak=1`, `alu_sel_a=1`.
  - `insn=32'h30002573` (csrr) -> both flags 0, no stall.
- Illegal: `code=10'b0000000011` -> `illegal=1`, sels 0, 2-cycle stall. `code=0` gives the same.
- Backpressure: `out_ready=0` for 4 cycles after a J result -> outputs stable, `in_ready=0`. Release -> next instruction accepted the same cycle.
- Reset in TRAP: ecall handed off, assert `rst_n=0` during the first busy cycle -> `trap_busy=0` and state IDLE after that edge.

Source files
------------

// File: rtl/alu_sel_ctrl_if.sv
// Handshake bundle for the operand-select decoder. Upstream offers an instruction
// class and word; downstream receives registered select lines and decode flags.
interface alu_sel_ctrl_if #(
    parameter int CODE_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] code;
    logic [31:0]       insn;
    logic              out_valid;
    logic              out_ready;
    logic              alu_sel_a;
    logic              alu_sel_b;
    logic              is_ecall;
    logic              is_ebreak;
    logic              illegal;
    logic              trap_busy;

    // Upstream/downstream environment side.
    modport master (
        output in_valid, code, insn, out_ready,
        input  in_ready, out_valid, alu_sel_a, alu_sel_b,
               is_ecall, is_ebreak, illegal, trap_busy
    );

    // Decoder side.
    modport slave (
        input  in_valid, code, insn, out_ready,
        output in_ready, out_valid, alu_sel_a, alu_sel_b,
               is_ecall, is_ebreak, illegal, trap_busy
    );
endinterface

// File: rtl/alu_sel_ctrl.sv
// Registered operand-select decoder with valid/ready handshake. Any ecall, ebreak
// or illegal class code, once handed downstream, stalls the input for TRAP_CYCLES.
module alu_sel_ctrl #(
    parameter int                CODE_W      = 10,
    parameter logic [CODE_W-1:0] SEL_A_MASK  = 10'b0000001001,
    parameter logic [CODE_W-1:0] SEL_B_MASK  = 10'b0111001111,
    parameter int                CSR_IDX     = 9,
    parameter int                TRAP_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_sel_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TRAP_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TRAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OUT = 2'd1,
        TRAP     = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             out_valid_reg;
    logic             sel_a_reg;
    logic             sel_b_reg;
    logic             ecall_reg;
    logic             ebreak_reg;
    logic             illegal_reg;
    logic             trap_busy_reg;

    logic [CODE_W-1:0] hit_a;
    logic [CODE_W-1:0] hit_b;
    logic              one_hot;
    logic              sys_match;
    logic              sel_a_next;
    logic              sel_b_next;
    logic              ecall_next;
    logic              ebreak_next;
    logic              illegal_next;
    logic              trap_next;
    logic              in_ready_int;
    logic              accept;
    logic              handoff;

    // Per-class mask hits; a one-hot code lights at most one bit of each vector.
    genvar gi;
    generate
        for (gi = 0; gi < CODE_W; gi++) begin : g_class
            assign hit_a[gi] = bus.code[gi] & SEL_A_MASK[gi];
            assign hit_b[gi] = bus.code[gi] & SEL_B_MASK[gi];
        end
    endgenerate

    // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
    assign one_hot = (bus.code != '0) && ((bus.code & (bus.code - CODE_W'(1))) == '0);

    // ECALL/EBREAK encodings differ only in bit 20; everything else must be zero.
    assign sys_match = bus.code[CSR_IDX]
                    && (bus.insn[31:21] == 11'd0)
                    && (bus.insn[19:7]  == 13'd0)
                    && (bus.insn[6:0]   == 7'h73);

    // Combinational decode of the offered instruction; invalid codes force all selects low.
    always_comb begin
        sel_a_next   = one_hot & ((|hit_a) | (bus.code[CSR_IDX] & bus.insn[20]));
        sel_b_next   = one_hot & (|hit_b);
        ecall_next   = one_hot & sys_match & ~bus.insn[20];
        ebreak_next  = one_hot & sys_match &  bus.insn[20];
        illegal_next = ~one_hot;
        trap_next    = ecall_next | ebreak_next | illegal_next;
    end

    assign in_ready_int = rst_n && (state_reg == IDLE) && (!out_valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && in_ready_int;
    assign handoff      = out_valid_reg && bus.out_ready;

    // Output register, valid flag and trap sequencer; reset discards any pending stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            sel_a_reg     <= 1'b0;
            sel_b_reg     <= 1'b0;
            ecall_reg     <= 1'b0;
            ebreak_reg    <= 1'b0;
            illegal_reg   <= 1'b0;
            trap_busy_reg <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                sel_a_reg     <= sel_a_next;
                sel_b_reg     <= sel_b_next;
                ecall_reg     <= ecall_next;
                ebreak_reg    <= ebreak_next;
                illegal_reg   <= illegal_next;
            end else if (handoff) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (accept && trap_next) begin
                        state_reg <= WAIT_OUT;
                    end
                end
                WAIT_OUT: begin
                    if (handoff) begin
                        state_reg     <= TRAP;
                        cnt_reg       <= CNT_LOAD;
                        trap_busy_reg <= 1'b1;
                    end
                end
                TRAP: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= IDLE;
                        trap_busy_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    trap_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.alu_sel_a = sel_a_reg;
    assign bus.alu_sel_b = sel_b_reg;
    assign bus.is_ecall  = ecall_reg;
    assign bus.is_ebreak = ebreak_reg;
    assign bus.illegal   = illegal_reg;
    assign bus.trap_busy = trap_busy_reg;
endmodule

// File: tb/tb_alu_sel_ctrl.sv
// Bench for alu_sel_ctrl: table of class/instruction vectors with expected results,
// a scoreboard queue filled on accept and drained on handoff, plus hand sequences
// for reset, backpressure, trap stall length and reset during the stall.
module tb_alu_sel_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_sel_ctrl_if #(.CODE_W(10)) bus ();

    alu_sel_ctrl #(
        .CODE_W      (10),
        .SEL_A_MASK  (10'b0000001001),
        .SEL_B_MASK  (10'b0111001111),
        .CSR_IDX     (9),
        .TRAP_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic a;
        logic b;
        logic ec;
        logic eb;
        logic ill;
    } res_t;

    typedef struct {
        logic [9:0]  code;
        logic [31:0] insn;
        res_t        exp;
    } vec_t;

    res_t sb_q[$];
    res_t cur_exp;
    res_t mon_exp;
    int   n_checks = 0;
    int   n_fail = 0;
    logic just_acc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Scoreboard: compare on handoff first, then record a newly accepted instruction.
    always @(negedge clk) begin
        if (just_acc) chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
        just_acc = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("result{a,b,ec,eb,ill}",
                    32'({bus.alu_sel_a, bus.alu_sel_b, bus.is_ecall, bus.is_ebreak, bus.illegal}),
                    32'(mon_exp));
                $display("handoff: a=%0b b=%0b ecall=%0b ebreak=%0b illegal=%0b",
                         bus.alu_sel_a, bus.alu_sel_b, bus.is_ecall, bus.is_ebreak, bus.illegal);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(cur_exp);
            just_acc = 1'b1;
        end
    end

    // Offer one instruction (called at posedge+1); returns at posedge+1 after the accept edge.
    task automatic send(input logic [9:0] c, input logic [31:0] w, input res_t e, output int waited);
        logic done;
        bus.code     = c;
        bus.insn     = w;
        cur_exp      = e;
        bus.in_valid = 1'b1;
        waited       = 0;
        done         = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited >= 20) begin
                    chk("send_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        $display("sent code=%03h insn=%08h waited=%0d", c, w, waited);
    endtask

    // Observe a window after a send: count busy cycles and check in_ready around them.
    task automatic check_stall(input int exp_busy);
        int   busy;
        logic prev;
        busy = 0;
        prev = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.trap_busy) begin
                busy++;
                chk("in_ready_during_stall", 32'(bus.in_ready), 32'd0);
            end
            if (prev && !bus.trap_busy) chk("in_ready_after_stall", 32'(bus.in_ready), 32'd1);
            prev = bus.trap_busy;
        end
        chk("stall_length", 32'(busy), 32'(exp_busy));
        @(posedge clk);
        #1;
    endtask

    vec_t       vecs[17];
    logic [1:0] ab_tab[10];
    logic [9:0] one_bit;
    int         w;
    logic       found;

    initial begin
        ab_tab = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        one_bit = 10'd1;
        for (int i = 0; i < 10; i++) begin
            vecs[i].code = one_bit << i;
            vecs[i].insn = 32'h0;
            vecs[i].exp  = '{a: ab_tab[i][1], b: ab_tab[i][0], ec: 1'b0, eb: 1'b0, ill: 1'b0};
        end
        vecs[10] = '{10'h200, 32'h00000073, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[11] = '{10'h200, 32'h00100073, '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[12] = '{10'h200, 32'h30002573, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[13] = '{10'h003, 32'h00000000, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[14] = '{10'h000, 32'h00000000, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[15] = '{10'h201, 32'h00000073, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[16] = '{10'h200, 32'h00200073, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};

        // Reset held three cycles with in_valid high.
        bus.in_valid  = 1'b1;
        bus.code      = 10'h001;
        bus.insn      = 32'h0;
        bus.out_ready = 1'b1;
        cur_exp       = '0;
        rst_n         = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs",
                32'({bus.in_ready, bus.out_valid, bus.alu_sel_a, bus.alu_sel_b,
                     bus.is_ecall, bus.is_ebreak, bus.illegal, bus.trap_busy}),
                32'd0);
        end
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Table: back-to-back class sweep, then SYSTEM/illegal vectors with stall checks.
        for (int i = 0; i < 17; i++) begin
            send(vecs[i].code, vecs[i].insn, vecs[i].exp, w);
            if (i < 10) begin
                chk("sweep_no_wait", 32'(w), 32'd0);
            end else begin
                check_stall((vecs[i].exp.ec || vecs[i].exp.eb || vecs[i].exp.ill) ? 2 : 0);
            end
        end

        // Backpressure: J result held four cycles, next instruction waiting.
        bus.out_ready = 1'b0;
        send(10'h001, 32'h0, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, w);
        bus.code     = 10'h010;
        bus.insn     = 32'h0;
        cur_exp      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold{ov,a,b,ec,eb,ill,ir}",
                32'({bus.out_valid, bus.alu_sel_a, bus.alu_sel_b, bus.is_ecall,
                     bus.is_ebreak, bus.illegal, bus.in_ready}),
                32'b1110000);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;

        // Reset during the first busy cycle after an ecall handoff.
        send(10'h200, 32'h00000073, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, w);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.trap_busy) found = 1'b1;
        end
        chk("trap_reached", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("trap_reset{busy,in_ready}", 32'({bus.trap_busy, bus.in_ready}), 32'b01);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
